// File: rtl/bc_polinomio_pkg.sv
// Shared definitions for the polynomial controller: state encoding, BO mux/operation
// codes and helpers. The BO bench reuses the same constants.
package bc_polinomio_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARGA_X = 3'd1,
    XX      = 3'd2,
    AX2     = 3'd3,
    BX      = 3'd4,
    SOMA1   = 3'd5,
    SOMAC   = 3'd6,
    FIM     = 3'd7
  } estado_t;

  localparam logic [1:0] M0_ZERO = 2'b00;
  localparam logic [1:0] M0_A    = 2'b01;
  localparam logic [1:0] M0_B    = 2'b10;
  localparam logic [1:0] M0_C    = 2'b11;

  localparam logic [1:0] M1_M0   = 2'b00;
  localparam logic [1:0] M1_R0   = 2'b01;
  localparam logic [1:0] M1_R2   = 2'b10;
  localparam logic [1:0] M1_R1   = 2'b11;

  localparam logic [1:0] M2_R0   = 2'b00;
  localparam logic [1:0] M2_M0   = 2'b01;
  localparam logic [1:0] M2_R2   = 2'b10;
  localparam logic [1:0] M2_R1   = 2'b11;

  localparam logic H_SOMA = 1'b0;
  localparam logic H_MULT = 1'b1;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lx;
    logic       lh;
    logic       ls;
  } ctrl_t;

  // Wait-counter width: max(1, ceil(log2(lat+1))).
  function automatic int unsigned largura_cont(input int unsigned lat);
    return (lat == 0) ? 1 : $clog2(lat + 1);
  endfunction

  function automatic estado_t proximo_passo(input estado_t e);
    case (e)
      CARGA_X: return XX;
      XX:      return AX2;
      AX2:     return BX;
      BX:      return SOMA1;
      SOMA1:   return SOMAC;
      SOMAC:   return FIM;
      default: return OCIOSO;
    endcase
  endfunction

endpackage

// File: rtl/bc_polinomio_if.sv
// Start/done handshake plus the control bus toward BO. The master modport is the
// controller; the slave modport is the system/BO side.
interface bc_polinomio_if;
  logic       iniciar;
  logic       cancela;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;
  logic       H;
  logic       LX;
  logic       LH;
  logic       LS;
  logic       ocupado;
  logic       pronto;

  modport master (
    input  iniciar, cancela,
    output M0, M1, M2, H, LX, LH, LS, ocupado, pronto
  );

  modport slave (
    output iniciar, cancela,
    input  M0, M1, M2, H, LX, LH, LS, ocupado, pronto
  );
endinterface

// File: rtl/bc_polinomio_contador_espera.sv
// Step wait counter: clear, enable and terminal-count flag. Up mode counts 0..LIMITE,
// down mode counts LIMITE..0; it holds at the terminal value until cleared.
module contador_espera
  import bc_polinomio_pkg::*;
#(
  parameter int unsigned LIMITE = 2,
  parameter int unsigned W      = largura_cont(LIMITE),
  parameter bit          DESC   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] LIM = W'(LIMITE);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = DESC ? (cnt_q == '0) : (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = DESC ? LIM : '0;
    end else if (en_i && !tc_o) begin
      cnt_d = DESC ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= DESC ? LIM : '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bc_polinomio.sv
// Control block for BO computing y = A*x^2 + B*x + C through a fixed six-step
// micro-program. Moore outputs are decoded from the state and the wait counter only.
module bc_polinomio
  import bc_polinomio_pkg::*;
#(
  parameter int unsigned LATENCIA = 2
) (
  input  logic           clk,
  input  logic           rst,
  bc_polinomio_if.master bus
);

  estado_t estado_q, estado_d;
  logic    tc;
  logic    em_passo;
  logic    limpa;
  ctrl_t   ctl;

  assign em_passo = estado_q inside {XX, AX2, BX, SOMA1, SOMAC};
  // Clearing on every state change makes each step start its count at zero.
  assign limpa    = (estado_d != estado_q) || !em_passo;

  contador_espera #(
    .LIMITE (LATENCIA),
    .W      (largura_cont(LATENCIA)),
    .DESC   (1'b0)
  ) u_contador (
    .clk   (clk),
    .rst   (rst),
    .clr_i (limpa),
    .en_i  (em_passo),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    if (estado_q == OCIOSO) begin
      if (bus.iniciar && !bus.cancela) estado_d = CARGA_X;
    end else if (bus.cancela) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        CARGA_X: estado_d = XX;
        FIM:     estado_d = OCIOSO;
        default: if (tc) estado_d = proximo_passo(estado_q);
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    case (estado_q)
      CARGA_X: ctl.lx = 1'b1;
      XX: begin
        ctl.m1 = M1_R0;  ctl.m2 = M2_R0;  ctl.h = H_MULT;  ctl.lh = tc;
      end
      AX2: begin
        ctl.m0 = M0_A;   ctl.m1 = M1_M0;  ctl.m2 = M2_R1;
        ctl.h  = H_MULT; ctl.lh = tc;
      end
      BX: begin
        ctl.m0 = M0_B;   ctl.m1 = M1_M0;  ctl.m2 = M2_R0;
        ctl.h  = H_MULT; ctl.ls = tc;
      end
      SOMA1: begin
        ctl.m1 = M1_R2;  ctl.m2 = M2_R1;  ctl.h = H_SOMA;  ctl.lh = tc;
      end
      SOMAC: begin
        ctl.m0 = M0_C;   ctl.m1 = M1_M0;  ctl.m2 = M2_R1;
        ctl.h  = H_SOMA; ctl.ls = tc;
      end
      default: ;
    endcase
  end

  assign bus.M0      = ctl.m0;
  assign bus.M1      = ctl.m1;
  assign bus.M2      = ctl.m2;
  assign bus.H       = ctl.h;
  assign bus.LX      = ctl.lx;
  assign bus.LH      = ctl.lh;
  assign bus.LS      = ctl.ls;
  assign bus.ocupado = (estado_q != OCIOSO);
  assign bus.pronto  = (estado_q == FIM);

endmodule
